// File: rtl/seat_claim_arbiter.sv
// Two-player desk claim arbiter. Book positions are registered, hit-tested against five desks,
// and same-desk conflicts are settled by a round-robin pointer. Tracks ownership, scores and game phase.

module seat_desk_hit #(
  parameter logic [9:0]  X1       = 10'd0,
  parameter logic [8:0]  Y1       = 9'd0,
  parameter int unsigned DESK_H   = 120,
  parameter int unsigned HIT_HALF = 30
) (
  input  logic [9:0] bx,
  input  logic [8:0] by,
  output logic       hit
);
  // One extra bit so the upper window bounds cannot wrap
  localparam logic [10:0] XL = {1'b0, X1} - 11'(HIT_HALF);
  localparam logic [10:0] XH = {1'b0, X1} + 11'(HIT_HALF);
  localparam logic [9:0]  YL = {1'b0, Y1};
  localparam logic [9:0]  YH = {1'b0, Y1} + 10'(DESK_H);

  assign hit = ({1'b0, bx} > XL) && ({1'b0, bx} < XH) &&
               ({1'b0, by} > YL) && ({1'b0, by} < YH);
endmodule

module seat_claim_arbiter #(
  parameter logic [49:0] DESK_X1   = {10'd420, 10'd160, 10'd180, 10'd230, 10'd320},
  parameter logic [44:0] DESK_Y1   = {9'd160, 9'd100, 9'd360, 9'd250, 9'd320},
  parameter int unsigned DESK_H    = 120,
  parameter int unsigned HIT_HALF  = 30,
  parameter int unsigned CLAIM_PTS = 2,
  parameter int unsigned TARGET    = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       clr,
  input  logic       req_a,
  input  logic [9:0] bx_a,
  input  logic [8:0] by_a,
  input  logic       req_b,
  input  logic [9:0] bx_b,
  input  logic [8:0] by_b,
  output logic       grant_a,
  output logic       grant_b,
  output logic [2:0] gdesk_a,
  output logic [2:0] gdesk_b,
  output logic [9:0] owner,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [1:0] phase,
  output logic [1:0] winner
);
  localparam int NUM_DESKS = 5;
  localparam int NUM_PLY   = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} phase_t;
  typedef struct packed {
    logic       req;
    logic [9:0] bx;
    logic [8:0] by;
  } claim_t;

  phase_t                             st, st_n;
  claim_t [NUM_PLY-1:0]               cin, cq;
  logic   [NUM_PLY-1:0][NUM_DESKS-1:0] hit, elig;
  logic   [NUM_PLY-1:0]               sel_vld, gnt;
  logic   [NUM_PLY-1:0][2:0]          sel;
  logic   [NUM_DESKS-1:0]             free;
  logic                               rr, rr_n;   // 0: A wins next conflict
  logic   [9:0]                       owner_n;
  logic   [3:0]                       sa_n, sb_n;
  logic   [4:0]                       sum_n;
  logic   [1:0]                       win_n;
  logic                               all_own, done;

  function automatic logic [3:0] add_sat(input logic [3:0] s);
    logic [4:0] t;
    t = {1'b0, s} + 5'(CLAIM_PTS);
    return (t > 5'd15) ? 4'd15 : t[3:0];
  endfunction

  // Requests are only captured while playing, so IDLE/OVER traffic never reaches evaluation
  assign cin[0] = '{req: req_a & (st == PLAY), bx: bx_a, by: by_a};
  assign cin[1] = '{req: req_b & (st == PLAY), bx: bx_b, by: by_b};

  for (genvar k = 0; k < NUM_DESKS; k++) begin : g_free
    assign free[k] = (owner[2*k +: 2] == 2'd0);
  end

  for (genvar p = 0; p < NUM_PLY; p++) begin : g_ply
    for (genvar k = 0; k < NUM_DESKS; k++) begin : g_desk
      seat_desk_hit #(
        .X1(DESK_X1[k*10 +: 10]), .Y1(DESK_Y1[k*9 +: 9]),
        .DESK_H(DESK_H), .HIT_HALF(HIT_HALF)
      ) u_hit (
        .bx(cq[p].bx), .by(cq[p].by), .hit(hit[p][k])
      );
    end
    assign elig[p] = hit[p] & free & {NUM_DESKS{cq[p].req}};
  end

  // Lowest eligible desk index wins (scan high to low, last write sticks)
  always_comb begin
    sel_vld = '0;
    sel     = '0;
    for (int p = 0; p < NUM_PLY; p++)
      for (int k = NUM_DESKS-1; k >= 0; k--)
        if (elig[p][k]) begin
          sel_vld[p] = 1'b1;
          sel[p]     = 3'(k + 1);
        end
  end

  always_comb begin
    gnt  = sel_vld;
    rr_n = rr;
    if (st != PLAY)
      gnt = '0;
    else if (&sel_vld && (sel[0] == sel[1])) begin
      gnt  = rr ? 2'b10 : 2'b01;
      rr_n = ~rr;
    end
    owner_n = owner;
    for (int k = 0; k < NUM_DESKS; k++) begin
      if (gnt[0] && sel[0] == 3'(k + 1)) owner_n[2*k +: 2] = 2'd1;
      if (gnt[1] && sel[1] == 3'(k + 1)) owner_n[2*k +: 2] = 2'd2;
    end
    sa_n    = gnt[0] ? add_sat(score_a) : score_a;
    sb_n    = gnt[1] ? add_sat(score_b) : score_b;
    sum_n   = {1'b0, sa_n} + {1'b0, sb_n};
    all_own = 1'b1;
    for (int k = 0; k < NUM_DESKS; k++)
      if (owner_n[2*k +: 2] == 2'd0) all_own = 1'b0;
    done = all_own || (32'(sum_n) >= TARGET);
  end

  always_comb begin
    st_n  = st;
    win_n = winner;
    case (st)
      IDLE: if (start) st_n = PLAY;
      PLAY: if (done) begin
        st_n  = OVER;
        win_n = (sa_n > sb_n) ? 2'd1 : (sb_n > sa_n) ? 2'd2 : 2'd3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st <= IDLE; rr <= 1'b0; cq <= '0; owner <= '0;
      score_a <= '0; score_b <= '0; winner <= '0;
      grant_a <= 1'b0; grant_b <= 1'b0; gdesk_a <= '0; gdesk_b <= '0;
    end else if (clr) begin
      st <= IDLE; rr <= 1'b0; cq <= '0; owner <= '0;
      score_a <= '0; score_b <= '0; winner <= '0;
      grant_a <= 1'b0; grant_b <= 1'b0; gdesk_a <= '0; gdesk_b <= '0;
    end else begin
      st      <= st_n;
      rr      <= rr_n;
      cq      <= cin;
      owner   <= owner_n;
      score_a <= sa_n;
      score_b <= sb_n;
      winner  <= win_n;
      grant_a <= gnt[0];
      grant_b <= gnt[1];
      gdesk_a <= gnt[0] ? sel[0] : 3'd0;
      gdesk_b <= gnt[1] ? sel[1] : 3'd0;
    end
  end

  assign phase = st;
endmodule

// File: doc/seat_claim_arbiter.md
Name: seat_claim_arbiter

Overview:
- Arbitrates two players' falling-book landings against five desks. Holds desk ownership, per-player scores and the game phase (IDLE/PLAY/OVER).
- Sits between the player/book motion logic and the VGA pixel mux and the 7-seg score display.
- Resolves simultaneous claims on the same desk with a fair round-robin pointer.

Parameters:
- DESK_X1, 50'h (packed 5x10b: desk5..desk1 = 420,160,180,230,320): desk left edge x. Desk1 is in bits [9:0].
- DESK_Y1, 45'h (packed 5x9b: desk5..desk1 = 160,100,360,250,320): desk top y.
- DESK_H, 120: desk height in rows.
- HIT_HALF, 30: half-width of the horizontal hit window around DESK_X1. Must be <= min DESK_X1.
- CLAIM_PTS, 2: points awarded per successful claim.
- TARGET, 10: combined score that ends the game.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  IDLE->PLAY request, level-sampled
- clr  in  1  synchronous restart to IDLE; clears all state
- req_a  in  1  player A book in flight, claim attempt this cycle
- bx_a  in  10  player A book x
- by_a  in  9  player A book y
- req_b  in  1  player B book in flight
- bx_b  in  10  player B book x
- by_b  in  9  player B book y
- grant_a  out  1  one-cycle pulse: A claimed a desk
- grant_b  out  1  one-cycle pulse: B claimed a desk
- gdesk_a  out  3  desk index 1..5 claimed by A, valid with grant_a
- gdesk_b  out  3  desk index 1..5 claimed by B, valid with grant_b
- owner  out  10  packed 2b per desk (desk1 in [1:0]): 0 free, 1 A, 2 B
- score_a  out  4  player A score
- score_b  out  4  player B score
- phase  out  2  0 IDLE, 1 PLAY, 2 OVER
- winner  out  2  valid in OVER: 1 A, 2 B, 3 tie

Behaviour:
- Reset (rstn low, async):
  - owner=0, scores=0, grants=0, gdesk=0, phase=IDLE, winner=0.
  - Round-robin pointer rr=A.
- clr has priority over everything except rstn. It gives the same values as reset, applied at the next edge.
- IDLE: requests are ignored. start=1 moves to PLAY at the next edge.
- Hit test for desk k, evaluated per requester:
  - Condition: bx > X1k-HIT_HALF and bx < X1k+HIT_HALF and by > Y1k and by < Y1k+DESK_H, all strict, unsigned.
  - A desk is eligible only if owner[k]==0.
- If a book overlaps several eligible desks, the lowest index wins.
- A request with no eligible hit is a miss: no grant and no state change. The requester retries on later cycles while its req stays high.
- Latency: a request sampled at edge N gives grant, gdesk, owner and score updates, all registered and visible after edge N+1. grant pulses are exactly 1 cycle.
- Different desks selected by A and B in the same cycle: both are granted.
- Same desk selected by both:
  - The rr holder is granted and rr flips to the other player.
  - The loser gets no grant this cycle. Next cycle it re-evaluates against the updated owner, i.e. it may select its next-lowest eligible desk.
- rr changes only on a conflict.
- Score: +CLAIM_PTS per grant, saturating at 15.
- End condition, evaluated on next-state values: all five owner fields nonzero, or score_a+score_b >= TARGET (5-bit sum).
  - When met, phase=OVER at the same edge as the completing grant.
  - winner is set from the next-state scores: higher score wins, equal gives 3.
- OVER: requests and start are ignored and owner/scores are frozen. Only clr or rstn leaves OVER.
- Ownership is never overwritten: an owned desk is never eligible.

Test Plan:
1. Reset/phase: assert rstn=0 mid-PLAY with desk1 owned -> owner=0, scores=0, phase=0 immediately (async). Then start=1 for 1 cycle -> phase=1 next edge.
2. Single claim: in PLAY, req_a=1, bx_a=320, by_a=400 -> one cycle later grant_a=1, gdesk_a=1, owner[1:0]=1, score_a=2. Repeating the same request gives no further grant.
3. Overlap priority: req_b, bx_b=205, by_b=365 (desk2 and desk3 windows) -> gdesk_b=2, owner[3:2]=2.
4. Conflict round-robin:
   - Both request bx=320, by=400 from reset -> A granted, B not, rr=B.
   - After clr + start, both hit desk4 (bx=160, by=150) twice with desk1 pre-owned by A -> first conflict to A.
   - Then both hit desk5 (bx=420, by=200) -> B granted.
5. End of game: claim desks in order A1, B2, A3, B4, A5 -> after the fifth grant phase=2 in the same cycle as grant_a, score_a=6, score_b=4, winner=1. Subsequent requests give no grant.
6. clr in OVER -> all cleared, phase=0. clr and req_a high in the same cycle -> no grant; state is cleared.
